// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue unit.
// Control codes, instruction field positions and operand-build modes.
package alu_pkg;

    localparam int DW      = 19;
    localparam int IW      = 6;
    localparam int INSTR_W = 19;

    localparam int OPC_HI = 18;
    localparam int OPC_LO = 15;
    localparam int RD_HI  = 14;
    localparam int RD_LO  = 12;

    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_AND   = 4'b0010;
    localparam logic [3:0] ALU_OR    = 4'b0011;
    localparam logic [3:0] ALU_ADDI  = 4'b0100;
    localparam logic [3:0] ALU_ANDI  = 4'b0101;
    localparam logic [3:0] ALU_SLT   = 4'b0110;
    localparam logic [3:0] ALU_LOAD  = 4'b0111;
    localparam logic [3:0] ALU_STORE = 4'b1000;
    localparam logic [3:0] ALU_LEA   = 4'b1011;
    localparam logic [3:0] ALU_MVS   = 4'b1100;
    localparam logic [3:0] ALU_NOP   = 4'b1111;

    // How the A/B operands are built from registers and immediate.
    typedef enum logic [1:0] {
        OPS_RR,
        OPS_SEXT,
        OPS_ZEXT,
        OPS_ZERO_SEXT
    } opsel_e;

endpackage

// File: rtl/alu_issue_if.sv
// Bundle of the issue-side, ALU-side and result-side signals.
// master = the issue unit, slave = its environment.
interface alu_issue_if #(
    parameter int DW = alu_pkg::DW
) ();

    logic          in_valid;
    logic          in_ready;
    logic [18:0]   instr;
    logic [DW-1:0] rs1_data;
    logic [DW-1:0] rs2_data;
    logic [DW-1:0] alu_a;
    logic [DW-1:0] alu_b;
    logic [3:0]    alu_ctrl;
    logic [DW-1:0] alu_result;
    logic          alu_zero;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_result;
    logic          out_zero;
    logic [2:0]    out_rd;
    logic          out_illegal;

    modport master (
        input  in_valid, instr, rs1_data, rs2_data,
        input  alu_result, alu_zero, out_ready,
        output in_ready, alu_a, alu_b, alu_ctrl,
        output out_valid, out_result, out_zero,
        output out_rd, out_illegal
    );

    modport slave (
        output in_valid, instr, rs1_data, rs2_data,
        output alu_result, alu_zero, out_ready,
        input  in_ready, alu_a, alu_b, alu_ctrl,
        input  out_valid, out_result, out_zero,
        input  out_rd, out_illegal
    );

endinterface

// File: rtl/alu_decode.sv
// Opcode decoder: ALU control code, illegal flag, operand mode.
// Defined opcodes pass through unchanged as the control code.
module alu_decode
    import alu_pkg::*;
(
    input  logic [3:0] opcode_i,
    output logic [3:0] ctrl_o,
    output logic       illegal_o,
    output opsel_e     opsel_o
);

    // Classify the opcode; anything undefined becomes a NOP issue.
    always_comb begin
        ctrl_o    = opcode_i;
        illegal_o = 1'b0;
        opsel_o   = OPS_RR;
        unique case (opcode_i)
            ALU_ADD, ALU_SUB, ALU_AND,
            ALU_OR, ALU_SLT:
                opsel_o = OPS_RR;
            ALU_ADDI, ALU_LOAD,
            ALU_STORE, ALU_LEA:
                opsel_o = OPS_SEXT;
            ALU_ANDI:
                opsel_o = OPS_ZEXT;
            ALU_MVS:
                opsel_o = OPS_ZERO_SEXT;
            default: begin
                ctrl_o    = ALU_NOP;
                illegal_o = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/alu_issue_unit.sv
// Two-stage ALU issue unit: S1 drives the external ALU,
// S2 captures its result behind a valid/ready output.
module alu_issue_unit
    import alu_pkg::*;
#(
    parameter int DW = alu_pkg::DW,
    parameter int IW = alu_pkg::IW
) (
    input  logic       clk,
    input  logic       reset,
    alu_issue_if.master bus
);

    logic [3:0]    opc;
    logic [IW-1:0] imm;
    logic [DW-1:0] imm_sx;
    logic [DW-1:0] imm_zx;
    logic [3:0]    ctrl_d;
    logic          ill_d;
    opsel_e        opsel;
    logic [DW-1:0] a_d;
    logic [DW-1:0] b_d;

    logic          s1_valid_q;
    logic [DW-1:0] s1_a_q;
    logic [DW-1:0] s1_b_q;
    logic [3:0]    s1_ctrl_q;
    logic [2:0]    s1_rd_q;
    logic          s1_ill_q;

    logic          s2_valid_q;
    logic [DW-1:0] s2_result_q;
    logic          s2_zero_q;
    logic [2:0]    s2_rd_q;
    logic          s2_ill_q;

    logic          s1_adv;
    logic          accept;

    assign opc    = bus.instr[OPC_HI:OPC_LO];
    assign imm    = bus.instr[IW-1:0];
    assign imm_sx = {{(DW-IW){imm[IW-1]}}, imm};
    assign imm_zx = {{(DW-IW){1'b0}}, imm};

    alu_decode u_dec (
        .opcode_i  (opc),
        .ctrl_o    (ctrl_d),
        .illegal_o (ill_d),
        .opsel_o   (opsel)
    );

    // Build A/B for the instruction being offered.
    always_comb begin
        a_d = bus.rs1_data;
        b_d = bus.rs2_data;
        unique case (opsel)
            OPS_RR:        b_d = bus.rs2_data;
            OPS_SEXT:      b_d = imm_sx;
            OPS_ZEXT:      b_d = imm_zx;
            OPS_ZERO_SEXT: begin
                a_d = '0;
                b_d = imm_sx;
            end
        endcase
    end

    assign s1_adv   = s1_valid_q && (!s2_valid_q || bus.out_ready);
    assign accept   = bus.in_valid && bus.in_ready;
    assign bus.in_ready = !s1_valid_q || s1_adv;

    // Issue stage: load on accept, empty when it moves on.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_ctrl_q  <= ALU_ADD;
            s1_rd_q    <= '0;
            s1_ill_q   <= 1'b0;
        end else if (accept) begin
            s1_valid_q <= 1'b1;
            s1_a_q     <= a_d;
            s1_b_q     <= b_d;
            s1_ctrl_q  <= ctrl_d;
            s1_rd_q    <= bus.instr[RD_HI:RD_LO];
            s1_ill_q   <= ill_d;
        end else if (s1_adv) begin
            s1_valid_q <= 1'b0;
        end
    end

    // Output stage: sample ALU on advance, payload held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_rd_q     <= '0;
            s2_ill_q    <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q  <= 1'b1;
            s2_result_q <= s1_ill_q ? '0 : bus.alu_result;
            s2_zero_q   <= s1_ill_q | bus.alu_zero;
            s2_rd_q     <= s1_rd_q;
            s2_ill_q    <= s1_ill_q;
        end else if (bus.out_ready) begin
            s2_valid_q  <= 1'b0;
        end
    end

    assign bus.alu_a       = s1_a_q;
    assign bus.alu_b       = s1_b_q;
    assign bus.alu_ctrl    = s1_ctrl_q;
    assign bus.out_valid   = s2_valid_q;
    assign bus.out_result  = s2_result_q;
    assign bus.out_zero    = s2_zero_q;
    assign bus.out_rd      = s2_rd_q;
    assign bus.out_illegal = s2_ill_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Bench for alu_issue_unit: directed cases, backpressure, reset,
// then random traffic against an instruction-level reference model.
module tb_alu_issue_unit;

    typedef struct {
        logic [18:0] res;
        logic        zero;
        logic [2:0]  rd;
        logic        ill;
        logic [3:0]  ctrl;
    } item_t;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    alu_issue_if #(.DW(19)) bus ();

    alu_issue_unit #(.DW(19), .IW(6)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vecs = 0;
    int          miscompares = 0;
    item_t       q[$];
    logic [18:0] popped[$];
    bit          just_acc = 0;

    // External ALU behaviour seen by the unit.
    function automatic logic [18:0] alu_f(logic [3:0] c,
                                          logic [18:0] a,
                                          logic [18:0] b);
        case (c)
            4'd0, 4'd4, 4'd7,
            4'd8, 4'd11, 4'd12: return a + b;
            4'd1:               return a - b;
            4'd2, 4'd5:         return a & b;
            4'd3:               return a | b;
            4'd6:               return (a < b) ? 19'd1 : 19'd0;
            default:            return 19'd0;
        endcase
    endfunction

    assign bus.alu_result = alu_f(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    assign bus.alu_zero   = (bus.alu_result == 19'd0);

    // Reference: what each instruction must produce.
    function automatic item_t model(logic [18:0] ins,
                                    logic [18:0] r1,
                                    logic [18:0] r2);
        item_t       it;
        logic [3:0]  opc;
        logic [18:0] sx;
        logic [18:0] zx;
        logic [18:0] r;
        bit          legal;
        opc   = ins[18:15];
        sx    = {{13{ins[5]}}, ins[5:0]};
        zx    = {13'd0, ins[5:0]};
        legal = 1;
        case (opc)
            4'd0:  r = r1 + r2;
            4'd1:  r = r1 - r2;
            4'd2:  r = r1 & r2;
            4'd3:  r = r1 | r2;
            4'd4:  r = r1 + sx;
            4'd5:  r = r1 & zx;
            4'd6:  r = (r1 < r2) ? 19'd1 : 19'd0;
            4'd7:  r = r1 + sx;
            4'd8:  r = r1 + sx;
            4'd11: r = r1 + sx;
            4'd12: r = sx;
            default: begin
                r     = 19'd0;
                legal = 0;
            end
        endcase
        it.res  = r;
        it.zero = (r == 19'd0);
        it.rd   = ins[14:12];
        it.ill  = !legal;
        it.ctrl = legal ? opc : 4'hF;
        return it;
    endfunction

    function automatic logic [18:0] mk(logic [3:0] o,
                                       logic [2:0] rd,
                                       logic [5:0] imm);
        return {o, rd, 3'd1, 3'd2, imm};
    endfunction

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check outputs at negedge, then update the model.
    task automatic cycle();
        bit    exp_rdy;
        bit    exp_ov;
        bit    acc;
        bit    pop;
        item_t nxt;
        @(negedge clk);
        exp_rdy = !(q.size() == 2 && !bus.out_ready);
        exp_ov  = (q.size() == 2) || (q.size() == 1 && !just_acc);
        chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
        chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
        if (exp_ov) begin
            chk("out_result", {13'd0, bus.out_result}, {13'd0, q[0].res});
            chk("out_zero", {31'd0, bus.out_zero}, {31'd0, q[0].zero});
            chk("out_rd", {29'd0, bus.out_rd}, {29'd0, q[0].rd});
            chk("out_illegal", {31'd0, bus.out_illegal},
                {31'd0, q[0].ill});
        end
        if (just_acc)
            chk("alu_ctrl", {28'd0, bus.alu_ctrl},
                {28'd0, q[q.size()-1].ctrl});
        acc = bus.in_valid && exp_rdy;
        pop = exp_ov && bus.out_ready;
        if (pop) popped.push_back(bus.out_result);
        if (acc) nxt = model(bus.instr, bus.rs1_data, bus.rs2_data);
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(nxt);
        just_acc = acc;
        #1;
    endtask

    task automatic directed(input string tag,
                            input logic [18:0] ins,
                            input logic [18:0] r1,
                            input logic [18:0] r2,
                            input logic [18:0] eres,
                            input logic ez,
                            input logic ei,
                            input logic [2:0] erd);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.instr     = ins;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        cycle();
        bus.in_valid = 1'b0;
        cycle();
        chk({tag, "_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, "_res"}, {13'd0, bus.out_result}, {13'd0, eres});
        chk({tag, "_zero"}, {31'd0, bus.out_zero}, {31'd0, ez});
        chk({tag, "_ill"}, {31'd0, bus.out_illegal}, {31'd0, ei});
        chk({tag, "_rd"}, {29'd0, bus.out_rd}, {29'd0, erd});
        cycle();
    endtask

    logic [18:0] sub_ins[4];
    logic [18:0] sub_a[4];
    logic [18:0] sub_b[4];
    logic [18:0] bp_exp[4];

    initial begin
        int idx;
        int n;
        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr     = '0;
        bus.rs1_data  = '0;
        bus.rs2_data  = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("rst_alu_a", {13'd0, bus.alu_a}, 32'd0);
        chk("rst_alu_b", {13'd0, bus.alu_b}, 32'd0);
        chk("rst_alu_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        chk("rst_out_result", {13'd0, bus.out_result}, 32'd0);
        chk("rst_out_zero", {31'd0, bus.out_zero}, 32'd0);
        chk("rst_out_rd", {29'd0, bus.out_rd}, 32'd0);
        chk("rst_out_illegal", {31'd0, bus.out_illegal}, 32'd0);

        bus.out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("idle_ctrl", {28'd0, bus.alu_ctrl}, 32'd0);
        end

        directed("add", mk(4'd0, 3'd3, 6'd0), 19'd5, 19'd7,
                 19'd12, 1'b0, 1'b0, 3'd3);
        directed("addi", mk(4'd4, 3'd1, 6'h3F), 19'h10, 19'd0,
                 19'h0F, 1'b0, 1'b0, 3'd1);
        directed("andi", mk(4'd5, 3'd2, 6'h3F), 19'h7FFFF, 19'd0,
                 19'h0003F, 1'b0, 1'b0, 3'd2);
        directed("mvs", mk(4'd12, 3'd4, 6'h20), 19'h12345, 19'd0,
                 19'h7FFE0, 1'b0, 1'b0, 3'd4);
        directed("illegal", mk(4'd10, 3'd5, 6'h11), 19'd9, 19'd4,
                 19'd0, 1'b1, 1'b1, 3'd5);
        directed("slt", mk(4'd6, 3'd6, 6'd0), 19'd3, 19'h40000,
                 19'd1, 1'b0, 1'b0, 3'd6);

        sub_a   = '{19'd9, 19'd3, 19'd0, 19'd8};
        sub_b   = '{19'd9, 19'd1, 19'd1, 19'd2};
        bp_exp  = '{19'd0, 19'd2, 19'h7FFFF, 19'd6};
        for (int i = 0; i < 4; i++)
            sub_ins[i] = mk(4'd1, 3'(i), 6'd0);
        popped.delete();
        idx = 0;
        n   = 0;
        while ((idx < 4 || q.size() != 0) && n < 40) begin
            bus.in_valid  = (idx < 4);
            bus.out_ready = (n >= 3);
            if (idx < 4) begin
                bus.instr    = sub_ins[idx];
                bus.rs1_data = sub_a[idx];
                bus.rs2_data = sub_b[idx];
            end
            if (n == 2)
                chk("bp_in_ready_full", {31'd0, bus.in_ready}, 32'd0);
            cycle();
            if (just_acc) idx++;
            n++;
        end
        chk("bp_timeout", {31'd0, n < 40}, 32'd1);
        chk("bp_count", popped.size(), 32'd4);
        for (int i = 0; i < 4 && i < popped.size(); i++)
            chk("bp_order", {13'd0, popped[i]}, {13'd0, bp_exp[i]});

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.instr     = mk(4'd0, 3'd7, 6'd0);
        bus.rs1_data  = 19'd1;
        bus.rs2_data  = 19'd1;
        cycle();
        bus.instr = mk(4'd3, 3'd6, 6'd0);
        cycle();
        bus.in_valid = 1'b0;
        chk("full_out_valid", {31'd0, bus.out_valid}, 32'd1);
        chk("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        reset    = 1'b0;
        q.delete();
        just_acc = 0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();

        for (int i = 0; i < 400; i++) begin
            bus.in_valid  = ($urandom % 4) != 0;
            bus.out_ready = ($urandom % 3) != 0;
            bus.instr     = 19'($urandom);
            bus.rs1_data  = 19'($urandom);
            bus.rs2_data  = 19'($urandom);
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (4) cycle();

        $display("== %0d vectors applied, %0d miscompares ==",
                 vecs, miscompares);
        $finish;
    end

endmodule
